// File: rtl/bch_pkg.sv
// Shared BCH(63,56) constants, state encoding and S_eoro field positions.
// Used by the syndrome front end, the error locator and the lookup tables.
package bch_pkg;

   localparam int         BCH_N   = 63;
   localparam int         BCH_K   = 56;
   localparam int         BCH_SW  = 7;
   localparam logic [7:0] BCH_GEN = 8'hC5;

   localparam int EORO_ODD = 0;
   localparam int EORO_NZ  = 1;
   localparam int EORO_UNC = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } bch_state_e;

endpackage

// File: rtl/bch_rem_step.sv
// Single-bit step of serial polynomial division by the generator.
// Shifts one coefficient into the remainder and folds back the overflow term.
module bch_rem_step #(
   parameter int         SW  = 7,
   parameter logic [SW:0] GEN = 8'hC5
) (
   input  logic [SW-1:0] rem,
   input  logic          din,
   output logic [SW-1:0] rem_next
);

   assign rem_next = {rem[SW-2:0], din} ^ ({SW{rem[SW-1]}} & GEN[SW-1:0]);

endmodule

// File: rtl/bch_syndrome_serial.sv
// Serial BCH(63,56) receive front end: assembles R, divides by g(x) on the fly,
// and holds S / S_eoro with isEn3 high until the decoder acknowledges.
//
//   state | meaning
//   IDLE  | waiting for a bit qualified by sof; other bits are dropped
//   SHIFT | frame in progress, one coefficient per accepted bit
//   HOLD  | results valid, input stalled until out_ack
module bch_syndrome_serial
   import bch_pkg::*;
#(
   parameter int          N   = BCH_N,
   parameter int          SW  = BCH_SW,
   parameter logic [SW:0] GEN = BCH_GEN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din,
   input  logic          din_valid,
   input  logic          sof,
   output logic          ready,
   output logic [N-1:0]  R,
   output logic [SW-1:0] S,
   output logic [2:0]    S_eoro,
   output logic          isEn3,
   input  logic          out_ack,
   output logic          sof_err
);

   localparam logic [5:0] LAST = 6'(N - 1);

   bch_state_e    state, state_next;
   logic [5:0]    count;
   logic [SW-1:0] rem, rem_in, rem_nx;
   logic          par, par_nx;
   logic          frame_start, frame_abort, shift_en, frame_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (din_valid && sof) state_next = SHIFT;
         SHIFT:   if (din_valid && !sof && count == LAST) state_next = HOLD;
         HOLD:    if (out_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready       = 1'b1;
      frame_start = 1'b0;
      frame_abort = 1'b0;
      shift_en    = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: frame_start = din_valid && sof;
         SHIFT: begin
            if (din_valid) begin
               if (sof) begin
                  frame_start = 1'b1;
                  frame_abort = 1'b1;
               end else begin
                  shift_en   = 1'b1;
                  frame_done = (count == LAST);
               end
            end
         end
         HOLD:    ready = 1'b0;
         default: ready = 1'b1;
      endcase
   end

   // A new frame divides from a zero remainder, so the first step seeds it with din.
   assign rem_in = frame_start ? '0 : rem;
   assign par_nx = (frame_start ? 1'b0 : par) ^ din;

   bch_rem_step #(.SW(SW), .GEN(GEN)) u_step (
      .rem      (rem_in),
      .din      (din),
      .rem_next (rem_nx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         R       <= '0;
         rem     <= '0;
         par     <= 1'b0;
         count   <= '0;
         S       <= '0;
         S_eoro  <= '0;
         isEn3   <= 1'b0;
         sof_err <= 1'b0;
      end else begin
         sof_err <= frame_abort;
         if (frame_start) begin
            R     <= {{(N-1){1'b0}}, din};
            rem   <= rem_nx;
            par   <= par_nx;
            count <= 6'd1;
         end else if (shift_en) begin
            R <= {R[N-2:0], din};
            if (frame_done) begin
               rem   <= '0;
               par   <= 1'b0;
               count <= '0;
            end else begin
               rem   <= rem_nx;
               par   <= par_nx;
               count <= (count == 6'd63) ? count : count + 6'd1;
            end
         end
         if (frame_done) begin
            S                <= rem_nx;
            S_eoro[EORO_ODD] <= par_nx;
            S_eoro[EORO_NZ]  <= |rem_nx;
            S_eoro[EORO_UNC] <= (|rem_nx) & ~par_nx;
            isEn3            <= 1'b1;
         end else if (state == HOLD && out_ack) begin
            isEn3 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// Scoreboard bench for bch_syndrome_serial: frames are queued with expected
// results and a monitor compares them whenever isEn3 rises.
module tb_bch_syndrome_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        din, din_valid, sof, out_ack;
   logic        ready, isEn3, sof_err;
   logic [62:0] R;
   logic [6:0]  S;
   logic [2:0]  S_eoro;

   typedef struct {
      logic [62:0] r;
      logic [6:0]  s;
      logic [2:0]  e;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   localparam logic [62:0] GPOLY = 63'hC5;

   bch_syndrome_serial dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .sof       (sof),
      .ready     (ready),
      .R         (R),
      .S         (S),
      .S_eoro    (S_eoro),
      .isEn3     (isEn3),
      .out_ack   (out_ack),
      .sof_err   (sof_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Long division of the 63-coefficient word by g(x).
   function automatic logic [6:0] poly_mod(input logic [62:0] r);
      logic [62:0] t;
      t = r;
      for (int i = 62; i >= 7; i--)
         if (t[i]) t = t ^ (GPOLY << (i - 7));
      return t[6:0];
   endfunction

   function automatic exp_t model(input logic [62:0] w);
      exp_t x;
      x.r = w;
      x.s = poly_mod(w);
      x.e = {(x.s != 0) & ~(^w), x.s != 0, ^w};
      return x;
   endfunction

   function automatic logic [62:0] encode(input logic [55:0] m);
      logic [62:0] c;
      c = {m, 7'b0};
      c[6:0] = poly_mod(c);
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic beat(input logic v, input logic s, input logic d, input logic a);
      din_valid = v;
      sof       = s;
      din       = d;
      out_ack   = a;
      @(posedge clk);
      #1;
   endtask

   task automatic send_partial(input logic [62:0] w, input int nbits);
      for (int k = 0; k < nbits; k++)
         beat(1'b1, k == 0, w[62-k], 1'b0);
   endtask

   task automatic run_frame(input exp_t x, input int duty, input int ack_delay,
                            input bit exp_abort, input bit chk_lat);
      int c0;
      int waits;
      exp_q.push_back(x);
      waits = 0;
      while (!ready && waits < 20) begin
         beat(1'b0, 1'b0, 1'b0, 1'b0);
         waits++;
      end
      chk("ready_before_frame", 64'(ready), 64'd1);
      c0 = cyc;
      for (int i = 62; i >= 0; i--) begin
         if (i < 62) begin
            while (duty < 100 && $urandom_range(99) >= duty) begin
               beat(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
               chk("stall_R", 64'(R), 64'(x.r >> (i + 1)));
            end
         end
         if (i == 0) chk("isEn3_before_last", 64'(isEn3), 64'd0);
         beat(1'b1, i == 62, x.r[i], 1'b0);
         if (i == 62) chk("sof_err_pulse", 64'(sof_err), 64'(exp_abort));
         if (i == 61 || (i < 62 && i > 58 && duty < 100))
            chk("sof_err_clear", 64'(sof_err), 64'd0);
      end
      chk("isEn3_at_last", 64'(isEn3), 64'd1);
      if (chk_lat) chk("latency", 64'(cyc - c0), 64'd63);
      for (int k = 0; k <= ack_delay; k++) begin
         chk("hold_ready", 64'(ready), 64'd0);
         chk("hold_isEn3", 64'(isEn3), 64'd1);
         chk("hold_R", 64'(R), 64'(x.r));
         chk("hold_S", 64'(S), 64'(x.s));
         chk("hold_eoro", 64'(S_eoro), 64'(x.e));
         if (k < ack_delay)
            beat(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      end
      beat(1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_ready", 64'(ready), 64'd1);
      chk("idle_isEn3", 64'(isEn3), 64'd0);
   endtask

   // Monitor: compares queued expectations on each rising isEn3.
   initial begin
      logic en_d;
      exp_t x;
      en_d = 1'b0;
      forever begin
         @(negedge clk);
         if (isEn3 && !en_d) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_isEn3", 64'd1, 64'd0);
            end else begin
               x = exp_q.pop_front();
               chk("mon_R", 64'(R), 64'(x.r));
               chk("mon_S", 64'(S), 64'(x.s));
               chk("mon_eoro", 64'(S_eoro), 64'(x.e));
               chk("mon_parity_inv", 64'(S_eoro[0]), 64'(^S));
            end
         end
         en_d = isEn3;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t x;
      logic [62:0] w;
      logic [55:0] m;
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0; out_ack = 1'b0;
      #12;
      chk("rst_R", 64'(R), 64'd0);
      chk("rst_S", 64'(S), 64'd0);
      chk("rst_eoro", 64'(S_eoro), 64'd0);
      chk("rst_isEn3", 64'(isEn3), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Bits without sof in IDLE are dropped.
      repeat (3) beat(1'b1, 1'b0, 1'b1, 1'b0);
      chk("idle_drop_R", 64'(R), 64'd0);

      x.r = 63'h0;  x.s = 7'h00; x.e = 3'b000; run_frame(x, 100, 0, 1'b0, 1'b1);
      x.r = 63'h1;  x.s = 7'h01; x.e = 3'b011; run_frame(x, 100, 0, 1'b0, 1'b1);
      x.r = 63'h80; x.s = 7'h45; x.e = 3'b011; run_frame(x, 100, 0, 1'b0, 1'b1);
      x.r = 63'h3;  x.s = 7'h03; x.e = 3'b110; run_frame(x, 100, 0, 1'b0, 1'b1);

      for (int f = 0; f < 5; f++) begin
         m = {$urandom, $urandom};
         w = encode(m);
         w[$urandom_range(62)] ^= 1'b1;
         run_frame(model(w), 60, (f == 0) ? 10 : int'($urandom_range(4)), 1'b0, 1'b0);
      end

      // sof re-asserted mid-frame restarts the frame.
      w = {$urandom, $urandom};
      send_partial(w, 29);
      w = {$urandom, $urandom};
      run_frame(model(w), 100, 1, 1'b1, 1'b1);

      // Reset mid-frame, then a clean frame.
      w = {$urandom, $urandom};
      send_partial(w, 40);
      #2 rst = 1'b1;
      #1;
      chk("midrst_R", 64'(R), 64'd0);
      chk("midrst_S", 64'(S), 64'd0);
      chk("midrst_isEn3", 64'(isEn3), 64'd0);
      chk("midrst_ready", 64'(ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      m = {$urandom, $urandom};
      w = encode(m);
      w[$urandom_range(62)] ^= 1'b1;
      run_frame(model(w), 80, 2, 1'b0, 1'b0);

      repeat (3) beat(1'b0, 1'b0, 1'b0, 1'b0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
